i2c_pos_reader: RTL and testbench

I2C master that polls the position-tracker slave over an open-drain two-wire bus. On each `start` request it generates START, sends the 7-bit slave address with R=1, reads three bytes (x position, y position, status), ACKs the first two, NACKs the last, and issues STOP. The three bytes are presented as registered outputs. The block sits on the host/test side of the bus, opposite the position/I2C-slave design, and drives both lines through pad output-enables. It serves bring-up and loopback checks.

---
 rtl/i2c_pos_reader.sv | 211 +++++++++++++++++++++
 tb/tb_i2c_pos_reader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_pos_reader.sv
// I2C read master for the position-tracker slave. It sends START and the address with R=1,
// reads three bytes (ACK, ACK, NACK), then sends STOP. Both lines are open-drain, driven through output enables.
module i2c_pos_reader #(
    parameter logic [6:0] I2C_ADDR = 7'b1100100,
    parameter int         CLK_DIV  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] x_pos,
    output logic [7:0] y_pos,
    output logic [7:0] status,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe
);

    // state   | meaning
    // IDLE    | bus released, waiting for start
    // START   | 2 quarters: SDA falls while SCL high, then SCL pulled
    // ADDR    | 8 bit slots of {I2C_ADDR, 1}
    // AACK    | slave acknowledge slot for the address
    // READ    | 8 bit slots shifting slave data into the shadow register
    // MACK    | master ACK (bytes 0,1) or NACK (byte 2)
    // STOP    | 3 quarters: SDA rises while SCL high
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_READ, S_MACK, S_STOP
    } state_t;

    localparam int             CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  QMAX = CW'(CLK_DIV - 1);

    state_t        state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [CW-1:0] qcnt_q, qcnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [7:0]    tx_q, tx_d;
    logic [23:0]   shadow_q, shadow_d;
    logic          nack_q, nack_d;
    logic          scl_s1, scl_s, sda_s1, sda_s;
    logic          busy_d, done_d, ack_err_d, scl_d, sda_d;
    logic [7:0]    x_d, y_d, status_d;
    logic [1:0]    last_phase;
    logic          q_end;

    // q2 is held open until the synchronized SCL is high, which gives the slave its stretch window
    assign q_end = (qcnt_q == QMAX) && ((phase_q != 2'd2) || scl_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1   <= 1'b1;
            scl_s    <= 1'b1;
            sda_s1   <= 1'b1;
            sda_s    <= 1'b1;
            state_q  <= S_IDLE;
            phase_q  <= '0;
            qcnt_q   <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            tx_q     <= '0;
            shadow_q <= '0;
            nack_q   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ack_err  <= 1'b0;
            x_pos    <= '0;
            y_pos    <= '0;
            status   <= '0;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
        end else begin
            scl_s1   <= scl_in;
            scl_s    <= scl_s1;
            sda_s1   <= sda_in;
            sda_s    <= sda_s1;
            state_q  <= state_d;
            phase_q  <= phase_d;
            qcnt_q   <= qcnt_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            tx_q     <= tx_d;
            shadow_q <= shadow_d;
            nack_q   <= nack_d;
            busy     <= busy_d;
            done     <= done_d;
            ack_err  <= ack_err_d;
            x_pos    <= x_d;
            y_pos    <= y_d;
            status   <= status_d;
            scl_oe   <= scl_d;
            sda_oe   <= sda_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        qcnt_d    = qcnt_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        tx_d      = tx_q;
        shadow_d  = shadow_q;
        nack_d    = nack_q;
        busy_d    = busy;
        done_d    = 1'b0;
        ack_err_d = ack_err;
        x_d       = x_pos;
        y_d       = y_pos;
        status_d  = status;

        case (state_q)
            S_START: last_phase = 2'd1;
            S_STOP:  last_phase = 2'd2;
            default: last_phase = 2'd3;
        endcase

        if (state_q == S_IDLE) begin
            if (start) begin
                state_d   = S_START;
                phase_d   = '0;
                qcnt_d    = '0;
                bit_d     = '0;
                byte_d    = '0;
                tx_d      = {I2C_ADDR, 1'b1};
                nack_d    = 1'b0;
                busy_d    = 1'b1;
                ack_err_d = 1'b0;
            end
        end else if (!q_end) begin
            if (qcnt_q != QMAX) qcnt_d = qcnt_q + 1'b1;
        end else begin
            qcnt_d = '0;
            if (phase_q == 2'd2) begin
                if (state_q == S_AACK) nack_d = sda_s;
                if (state_q == S_READ) shadow_d = {shadow_q[22:0], sda_s};
            end
            if (phase_q != last_phase) begin
                phase_d = phase_q + 2'd1;
            end else begin
                phase_d = '0;
                case (state_q)
                    S_START: state_d = S_ADDR;
                    S_ADDR: begin
                        tx_d  = {tx_q[6:0], 1'b0};
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = S_AACK;
                    end
                    S_AACK: begin
                        bit_d   = '0;
                        state_d = nack_q ? S_STOP : S_READ;
                    end
                    S_READ: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = S_MACK;
                    end
                    S_MACK: begin
                        if (byte_q == 2'd2) begin
                            state_d = S_STOP;
                        end else begin
                            state_d = S_READ;
                            byte_d  = byte_q + 2'd1;
                        end
                    end
                    S_STOP: begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        if (nack_q) begin
                            ack_err_d = 1'b1;
                        end else begin
                            x_d      = shadow_q[23:16];
                            y_d      = shadow_q[15:8];
                            status_d = shadow_q[7:0];
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        // Line drive follows the next state/phase, so the registered enables move only on phase boundaries
        scl_d = 1'b0;
        sda_d = 1'b0;
        case (state_d)
            S_START: begin
                scl_d = (phase_d == 2'd1);
                sda_d = 1'b1;
            end
            S_ADDR: begin
                scl_d = !phase_d[1];
                sda_d = !tx_d[7];
            end
            S_AACK, S_READ: scl_d = !phase_d[1];
            S_MACK: begin
                scl_d = !phase_d[1];
                sda_d = (byte_d != 2'd2);
            end
            S_STOP: begin
                scl_d = (phase_d == 2'd0);
                sda_d = (phase_d != 2'd2);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_i2c_pos_reader.sv
// Bench for i2c_pos_reader: behavioural slave at 0x64 on an open-drain bus; per-transaction
// expectations are queued at stimulus time and checked by a monitor on each done pulse.
module tb_i2c_pos_reader;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, ack_err;
    logic [7:0] x_pos, y_pos, status;
    logic       scl_in, sda_in, scl_oe, sda_oe;
    logic       hold = 1'b0;
    logic       slv_sda_low = 1'b0;

    assign scl_in = !(scl_oe || hold);
    assign sda_in = !(sda_oe || slv_sda_low);

    i2c_pos_reader #(.I2C_ADDR(7'b1100100), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .ack_err(ack_err), .x_pos(x_pos), .y_pos(y_pos), .status(status),
        .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] st;
        logic       aerr;
        int         cycles;
        logic [2:0] mack;
    } exp_t;
    exp_t expq[$];

    task automatic push_exp(input logic [7:0] x, input logic [7:0] y, input logic [7:0] st,
                            input logic aerr, input int cycles, input logic [2:0] mack);
        exp_t e;
        e.x = x; e.y = y; e.st = st; e.aerr = aerr; e.cycles = cycles; e.mack = mack;
        expq.push_back(e);
    endtask

    // ---------------- behavioural slave / bus observer ----------------
    logic       slv_en = 1'b0;
    logic       stretch_en = 1'b0;
    logic [7:0] sdata [3];
    logic [7:0] addr_sh = '0;
    logic [2:0] mack_seen = '0;
    logic       stop_seen = 1'b0;

    initial begin
        int   cyc, fidx, stretch_at, b, i;
        logic p_scl, p_sda, sb, db, active, ack_given, armed;
        cyc = 0; fidx = 0; stretch_at = 0;
        p_scl = 1'b1; p_sda = 1'b1; active = 1'b0; ack_given = 1'b0; armed = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                slv_sda_low = 1'b0;
                hold = 1'b0;
                active = 1'b0;
                armed = 1'b0;
                p_scl = 1'b1;
                p_sda = 1'b1;
            end else begin
                sb = scl_in;
                db = sda_in;
                if (p_scl && sb && p_sda && !db) begin
                    active = 1'b1; fidx = -1; addr_sh = '0; ack_given = 1'b0;
                    stop_seen = 1'b0; armed = 1'b0;
                end else if (p_scl && sb && !p_sda && db) begin
                    active = 1'b0; stop_seen = 1'b1; slv_sda_low = 1'b0;
                end else if (active) begin
                    if (p_scl && !sb) begin
                        fidx++;
                        slv_sda_low = 1'b0;
                        if (fidx == 8) begin
                            ack_given = slv_en && (addr_sh == 8'hC9);
                            slv_sda_low = ack_given;
                        end else if (ack_given && fidx >= 9 && fidx <= 34) begin
                            b = (fidx - 9) / 9;
                            i = (fidx - 9) % 9;
                            if (i < 8) slv_sda_low = !sdata[b][7-i];
                        end
                        // pull SCL from the last cycle of q1 of slot 12 for 50 cycles
                        if (stretch_en && fidx == 12) begin
                            armed = 1'b1;
                            stretch_at = cyc + 7;
                        end
                    end
                    if (!p_scl && sb) begin
                        if (fidx >= 0 && fidx < 8) addr_sh = {addr_sh[6:0], db};
                        if (fidx == 17) mack_seen[0] = db;
                        if (fidx == 26) mack_seen[1] = db;
                        if (fidx == 35) mack_seen[2] = db;
                    end
                end
                hold = armed && (cyc >= stretch_at) && (cyc < stretch_at + 50);
                p_scl = sb;
                p_sda = db;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        int   bcnt;
        exp_t e;
        bcnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bcnt = 0;
            end else begin
                if (busy) bcnt++;
                if (done) begin
                    check("done_has_expect", int'(expq.size() != 0), 1);
                    if (expq.size() != 0) begin
                        e = expq.pop_front();
                        check("x_pos", int'(x_pos), int'(e.x));
                        check("y_pos", int'(y_pos), int'(e.y));
                        check("status", int'(status), int'(e.st));
                        check("ack_err", int'(ack_err), int'(e.aerr));
                        check("busy_cycles", bcnt, e.cycles);
                        check("addr_on_bus", int'(addr_sh), 8'hC9);
                        check("stop_on_bus", int'(stop_seen), 1);
                        if (!e.aerr) check("mack_bits", int'(mack_seen), int'(e.mack));
                    end
                    bcnt = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic got;
        got = 1'b0;
        for (int n = 0; n < 3000 && !got; n++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check({tag, "_done_seen"}, int'(got), 1);
    endtask

    initial begin
        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ack_err", int'(ack_err), 0);
        check("rst_data", int'({x_pos, y_pos, status}), 0);
        check("rst_scl_oe", int'(scl_oe), 0);
        check("rst_sda_oe", int'(sda_oe), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_bus", int'({scl_in, sda_in, busy}), 3'b110);

        // nominal read
        slv_en = 1'b1;
        sdata[0] = 8'h12; sdata[1] = 8'h34; sdata[2] = 8'hC9;
        push_exp(8'h12, 8'h34, 8'hC9, 1'b0, 596, 3'b100);
        pulse_start();
        check("busy_after_start", int'(busy), 1);
        wait_done("nominal");

        // start pulsed mid-transfer is ignored
        sdata[0] = 8'h5A; sdata[1] = 8'hF0; sdata[2] = 8'h01;
        push_exp(8'h5A, 8'hF0, 8'h01, 1'b0, 596, 3'b100);
        pulse_start();
        repeat (200) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored_start");
        repeat (5) @(negedge clk);
        check("no_restart", int'(busy), 0);

        // no slave: address NACK, data retained
        slv_en = 1'b0;
        push_exp(8'h5A, 8'hF0, 8'h01, 1'b1, 164, 3'b000);
        pulse_start();
        wait_done("nack");
        repeat (5) @(negedge clk);
        check("ack_err_held", int'(ack_err), 1);

        // clock stretching in slot 12; accepting start clears ack_err
        slv_en = 1'b1;
        stretch_en = 1'b1;
        sdata[0] = 8'h12; sdata[1] = 8'h34; sdata[2] = 8'hC9;
        push_exp(8'h12, 8'h34, 8'hC9, 1'b0, 644, 3'b100);
        pulse_start();
        check("ack_err_cleared", int'(ack_err), 0);
        wait_done("stretch");
        stretch_en = 1'b0;

        // reset during READ releases both lines at once
        pulse_start();
        repeat (250) @(negedge clk);
        check("mid_read_scl_pulled", int'(scl_oe), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_lines", int'({scl_oe, sda_oe}), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_data", int'({x_pos, y_pos, status}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // back-to-back with start held high
        sdata[0] = 8'hA5; sdata[1] = 8'h3C; sdata[2] = 8'h7E;
        push_exp(8'hA5, 8'h3C, 8'h7E, 1'b0, 596, 3'b100);
        push_exp(8'hA5, 8'h3C, 8'h7E, 1'b0, 596, 3'b100);
        @(negedge clk);
        start = 1'b1;
        wait_done("b2b_first");
        @(negedge clk);
        check("b2b_no_gap", int'(busy), 1);
        wait_done("b2b_second");
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("b2b_stopped", int'(busy), 0);
        check("queue_drained", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
